// File: rtl/vin_ps2_pkg.sv
// Shared types and constants for the vin PS/2 keyboard receiver.
// Event layout: {ext, brk, code[7:0]}.
package vin_ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int EV_W        = 10;
  localparam int EV_CODE_LSB = 0;
  localparam int EV_BRK_BIT  = 8;
  localparam int EV_EXT_BIT  = 9;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_ev_t;

  function automatic logic odd_parity(
    input logic [7:0] b,
    input logic       p
  );
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO for decoded key events.
// A push while full is accepted only when a pop frees the slot.
import vin_ps2_pkg::*;

module ps2_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [EV_W-1:0]         push_data,
  input  logic                    pop_req,
  output logic                    valid,
  output logic [EV_W-1:0]         rd_data,
  output logic                    full,
  output logic                    pop,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [EV_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            empty;
  logic            wr_en;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign pop     = pop_req && !empty;
  assign wr_en   = push && (!full || pop);
  assign valid   = !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/vin_ps2_rx.sv
// PS/2 keyboard receiver: sync + deglitch, frame FSM with timeout,
// E0/F0 prefix folding and a buffered key-event stream.
import vin_ps2_pkg::*;

module vin_ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8,
  parameter int PARITY_CHECK   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [EV_W-1:0]              ev_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [15:0]                  code,
  output logic                         err_parity,
  output logic                         err_frame,
  output logic                         overflow,
  input  logic                         err_clr
);

  localparam int CW   = $clog2(FILTER_LEN);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   FL_MAX = CW'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      clk_sync;
  logic [1:0]      dat_sync;
  logic            clk_f;
  logic            dat_f;
  logic [CW-1:0]   clk_cnt;
  logic [CW-1:0]   dat_cnt;
  logic            fall;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TO_W-1:0] tcnt;
  logic            timeout;
  logic            accept;
  logic            perr;
  logic            ferr;

  logic            ext_q;
  logic            brk_q;
  logic            push_q;
  ps2_ev_t         push_ev;
  logic            fifo_full;
  logic            fifo_pop;
  logic            drop;

  // Synchronisers preset to the idle-bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_f   <= 1'b1;
      clk_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_f) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FL_MAX) begin
        clk_f   <= clk_sync[1];
        clk_cnt <= '0;
        fall    <= clk_f;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_f   <= 1'b1;
      dat_cnt <= '0;
    end else if (dat_sync[1] == dat_f) begin
      dat_cnt <= '0;
    end else if (dat_cnt == FL_MAX) begin
      dat_f   <= dat_sync[1];
      dat_cnt <= '0;
    end else begin
      dat_cnt <= dat_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && !fall && (tcnt == TO_MAX);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    perr      = 1'b0;
    ferr      = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
      ferr      = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!dat_f) state_nxt = DATA;
          else        ferr      = 1'b1;
        end
        DATA: begin
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if (!dat_f)
            ferr = 1'b1;
          else if (PARITY_CHECK != 0 &&
                   !odd_parity(shreg, par_bit))
            perr = 1'b1;
          else
            accept = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE || fall || timeout)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;
      if (fall) begin
        unique case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shreg   <= {dat_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par_bit <= dat_f;
          default: ;
        endcase
      end
    end
  end

  // Prefix bytes only arm flags; any other byte emits one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      push_q     <= 1'b0;
      push_ev    <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      err_parity <= perr;
      err_frame  <= ferr;
      if (perr || ferr) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (accept) begin
        code <= {code[7:0], shreg};
        unique case (1'b1)
          (shreg == PS2_EXT): ext_q <= 1'b1;
          (shreg == PS2_BRK): brk_q <= 1'b1;
          default: begin
            push_q  <= 1'b1;
            push_ev <= '{ext: ext_q, brk: brk_q, code: shreg};
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (push_ev),
    .pop_req   (ev_ready),
    .valid     (ev_valid),
    .rd_data   (ev_data),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .count     (fifo_count)
  );

  assign drop = push_q && fifo_full && !fifo_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (err_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_vin_ps2_rx.sv
// Directed + randomized bench for vin_ps2_rx against a byte-level
// model of the PS/2 prefix folding and event queue.
module tb_vin_ps2_rx;

  localparam int FL    = 4;
  localparam int TO    = 300;
  localparam int DEPTH = 8;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ev_ready;
  logic       err_clr;

  logic       ev_valid;
  logic [9:0] ev_data;
  logic [3:0] fifo_count;
  logic [15:0] code;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;

  logic       ev_valid2;
  logic [9:0] ev_data2;
  logic [3:0] fifo_count2;
  logic [15:0] code2;
  logic       err_parity2;
  logic       err_frame2;
  logic       overflow2;
  logic       ev_ready2 = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int np = 0;
  int nf = 0;

  logic [9:0]  q1[$];
  logic [9:0]  q2[$];
  logic [9:0]  exp_q[$];
  logic        m_ext;
  logic        m_brk;
  logic [15:0] m_code;

  vin_ps2_rx #(
    .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH(DEPTH), .PARITY_CHECK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_data(ev_data), .fifo_count(fifo_count),
    .code(code), .err_parity(err_parity),
    .err_frame(err_frame), .overflow(overflow),
    .err_clr(err_clr)
  );

  vin_ps2_rx #(
    .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH(DEPTH), .PARITY_CHECK(0)
  ) dut_np (
    .clk(clk), .rst_n(rst_n),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid2), .ev_ready(ev_ready2),
    .ev_data(ev_data2), .fifo_count(fifo_count2),
    .code(code2), .err_parity(err_parity2),
    .err_frame(err_frame2), .overflow(overflow2),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ev_valid && ev_ready) q1.push_back(ev_data);
    if (ev_valid2) q2.push_back(ev_data2);
    if (err_parity) np++;
    if (err_frame) nf++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b,
                                        input logic flip,
                                        input logic bad_stop);
    logic p;
    p = (~^b) ^ flip;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      idle(HALF);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_code = {m_code[7:0], b};
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_err();
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic flip,
                      input logic bad_stop);
    send_bits(frame(b, flip, bad_stop), 11);
    idle(30);
    if (flip || bad_stop) model_err();
    else model_byte(b);
  endtask

  task automatic check_events(input string tag);
    int n;
    check({tag, " n"}, q1.size(), exp_q.size());
    n = (q1.size() < exp_q.size()) ? q1.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({tag, " ev"}, q1[i], exp_q[i]);
    q1.delete();
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ev_valid"}, ev_valid, 0);
    check({tag, " ev_data"}, ev_data, 0);
    check({tag, " fifo_count"}, fifo_count, 0);
    check({tag, " code"}, code, 0);
    check({tag, " err_parity"}, err_parity, 0);
    check({tag, " err_frame"}, err_frame, 0);
    check({tag, " overflow"}, overflow, 0);
  endtask

  initial begin
    int np0;
    int nf0;
    int exp_np;
    int exp_nf;
    logic [7:0] b;
    logic bad_p;
    logic bad_s;

    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    ev_ready = 1'b1;
    err_clr  = 1'b0;
    m_ext    = 1'b0;
    m_brk    = 1'b0;
    m_code   = '0;
    idle(5);
    check_reset("reset");
    rst_n = 1'b1;
    idle(10);

    send(8'h1C, 1'b0, 1'b0);
    check_events("make 1C");
    check("code 1C", code, 16'h001C);
    check("no perr", np, 0);
    check("no ferr", nf, 0);

    send(8'hE0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'h75, 1'b0, 1'b0);
    check_events("ext brk 75");
    check("code F075", code, 16'hF075);
    send(8'h75, 1'b0, 1'b0);
    check_events("make 75");
    check("code model", code, m_code);

    q2.delete();
    np0 = np;
    send(8'h1C, 1'b1, 1'b0);
    check_events("bad parity");
    check("code kept", code, m_code);
    check("perr pulse", np, np0 + 1);
    check("nocheck n", q2.size(), 1);
    check("nocheck ev", q2.size() > 0 ? q2[0] : 10'h3FF, 10'h01C);

    nf0 = nf;
    ps2_clk = 1'b0;
    idle(1);
    ps2_clk = 1'b1;
    idle(10);
    ps2_clk = 1'b0;
    idle(FL - 1);
    ps2_clk = 1'b1;
    idle(20);
    check("glitch ferr", nf, nf0);
    check_events("glitch");

    send_bits(frame(8'h5A, 1'b0, 1'b0), 5);
    idle(TO - 60);
    check("timeout early", nf, nf0);
    idle(120);
    check("timeout ferr", nf, nf0 + 1);
    model_err();
    send(8'h1C, 1'b0, 1'b0);
    check_events("after timeout");
    check("code after to", code, m_code);

    ev_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      send(8'($urandom_range(1, 8'hDF)), 1'b0, 1'b0);
    void'(exp_q.pop_back());
    check("ovf count", fifo_count, DEPTH);
    check("ovf flag", overflow, 1);
    check("ovf valid", ev_valid, 1);
    check("ovf head", ev_data, exp_q[0]);
    ev_ready = 1'b1;
    idle(20);
    check_events("ovf drain");
    check("ovf sticky", overflow, 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(1);
    check("ovf clr", overflow, 0);

    send_bits(frame(8'h29, 1'b0, 1'b0), 6);
    rst_n = 1'b0;
    idle(3);
    check_reset("midframe rst");
    rst_n = 1'b1;
    idle(3);
    check_reset("after rst");
    q1.delete();
    exp_q.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_code = '0;
    np0 = np;
    nf0 = nf;
    send(8'h29, 1'b0, 1'b0);
    check_events("post rst 29");
    check("code 29", code, 16'h0029);

    exp_np = np0;
    exp_nf = nf0;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        default: b = 8'($urandom_range(1, 8'hDF));
      endcase
      bad_p = ($urandom_range(0, 7) == 0);
      bad_s = !bad_p && ($urandom_range(0, 9) == 0);
      if (bad_p) exp_np++;
      if (bad_s) exp_nf++;
      send(b, bad_p, bad_s);
    end
    check_events("random");
    check("random code", code, m_code);
    check("random perr", np, exp_np);
    check("random ferr", nf, exp_nf);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vin_ps2_rx.md
# vin_ps2_rx

PS/2 keyboard receiver, fully synchronous to the system clock. It oversamples and deglitches the PS/2 lines and checks parity, framing and inter-bit timeout. It folds E0/F0 prefixes into key events and buffers those events in a parametrised FIFO with a valid/ready handshake. It sits in the vin plugin tier and feeds LinuxCNC input pins; a legacy 16-bit two-byte `code` view is retained for existing mappings.

## Interface
- FILTER_LEN, 4: consecutive identical synchronised samples required to accept a level change on ps2_clk / ps2_data (2..16).
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered ps2_clk falling edge, while mid-frame, before abort (2 ms at 50 MHz).
- FIFO_DEPTH, 8: event FIFO entries, power of two, 2..64.
- PARITY_CHECK, 1: 1 = discard bytes with even parity; 0 = ignore the parity bit.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- ev_valid  out  1  FIFO non-empty; reset 0.
- ev_ready  in  1  consumer accepts ev_data when high with ev_valid.
- ev_data  out  10  {ext, brk, code[7:0]} of FIFO head; reset 0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy; reset 0.
- code  out  16  last two accepted raw bytes, newest in [7:0]; reset 16'h0000.
- err_parity  out  1  one-cycle pulse per parity-failed byte; reset 0.
- err_frame  out  1  one-cycle pulse per bad start/stop bit or timeout; reset 0.
- overflow  out  1  sticky, set when an event is dropped on full FIFO; reset 0.
- err_clr  in  1  synchronous clear of overflow.

## Operation
- Input path: 2-FF synchroniser per line, then a FILTER_LEN counter filter. The filtered level changes only after FILTER_LEN equal samples. Filtered ps2_clk falling edge = `fall` strobe, 1 cycle.
- Frame FSM, advanced only on `fall`, sampling filtered data:
  - IDLE: data=0 -> DATA, bit counter 0. Data=1 -> err_frame, stay IDLE.
  - DATA: shift LSB first; after the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: data=1 and parity odd (or PARITY_CHECK=0) -> byte accepted. Data=0 -> err_frame. Parity bad (with data=1) -> err_parity only. Always -> IDLE.
- Timeout: in any state other than IDLE, a counter increments each cycle and clears on `fall`. Reaching TIMEOUT_CYCLES -> err_frame, FSM to IDLE, partial byte discarded.
- Accepted byte: `code <= {code[7:0], byte}` (every byte, prefixes included). Then decode:
  - 8'hE0 sets ext.
  - 8'hF0 sets brk.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
- Any parity/frame error clears ext and brk.
- FIFO: first-word-fall-through. Pop when ev_valid && ev_ready.
  - Push when full without a same-cycle pop: drop the new event, set overflow.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push when empty: ev_valid rises next cycle.
- err_clr and a new overflow in the same cycle: overflow stays set.
- Reset mid-frame: FSM IDLE, flags cleared, FIFO emptied, filters preset to 1 (idle bus). The next `fall` must be a start bit.

## Timing
- Raw edge -> `fall`: 2 (sync) + FILTER_LEN cycles.
- `fall` on stop bit -> code updated: 1 cycle. -> ev_valid / fifo_count updated: 2 cycles.
- err_* pulses are asserted 1 cycle after the causing `fall` or after the timeout terminal count.
- Throughput: one event per frame; bounded by PS/2 rate, never by clk.
- ev_data is stable while ev_valid && !ev_ready.

## Structure
- Package vin_ps2_pkg holds:
  - state enum {IDLE, DATA, PARITY, STOP};
  - PS2_EXT=8'hE0, PS2_BRK=8'hF0;
  - EV_W=10 and the event field offsets.
- Sub-module ps2_event_fifo: parametrised sync FWFT FIFO, EV_W wide, FIFO_DEPTH deep, with count output. The synchroniser/filter and FSM stay in vin_ps2_rx.

## Test plan
- Frame 0x1C (odd parity bit 0, stop 1) at 12.5 kHz, FILTER_LEN=4 -> one event ev_data=10'h01C, code=16'h001C, no errors.
- Sequence E0,F0,75 -> single event ev_data=10'h375, code=16'hF075. A following 75 -> ev_data=10'h075.
- Frame 0x1C with parity bit flipped -> err_parity pulse, no event, code unchanged. With PARITY_CHECK=0 -> event 10'h01C.
- 1-cycle and FILTER_LEN-1 cycle glitches on ps2_clk during IDLE -> no `fall`, FSM stays IDLE. Stop 4 bits into a frame -> err_frame after TIMEOUT_CYCLES. A following clean 0x1C is received.
- ev_ready=0, FIFO_DEPTH=8, 9 make codes -> fifo_count=8, overflow=1, head = first code. Pop all -> order preserved. err_clr -> overflow=0.
- Assert rst_n low after bit 5 of a frame -> all outputs at reset values. Next full frame 0x29 -> event 10'h029.
